// File: rtl/sel_dec_pkg.sv
// Shared definitions for the register-select decoder: default sizes,
// FSM state encoding and the code wrap rule used when sweeping registers.
package sel_dec_pkg;

    localparam int DEF_CODE_W  = 5;
    localparam int DEF_NUM_OUT = 32;

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    // Successor of a register code during a sweep. The last selectable code
    // and any out-of-range code both wrap back to register 0.
    function automatic logic [31:0] code_next(input logic [31:0] code,
                                              input int unsigned num_out);
        if (code >= num_out - 1)
            return '0;
        else
            return code + 32'd1;
    endfunction

endpackage

// File: rtl/onehot_decode.sv
// Combinational register code to one-hot select. Codes beyond the number
// of selectable registers produce an all-zero word.
module onehot_decode #(
    parameter int CODE_W  = 5,
    parameter int NUM_OUT = 32
) (
    input  logic [CODE_W-1:0]  code,
    output logic [NUM_OUT-1:0] onehot
);

    // Each select bit fires only when the code names exactly that register.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
            onehot[i] = (32'(code) == 32'(i));
        end
    end

endmodule

// File: rtl/reg_select_decoder.sv
// Register-select decoder: turns a register number into a registered
// one-hot select word behind a valid/ready handshake, optionally sweeping a
// run of consecutive registers one beat per transfer.
// Optional feature macro: SEL_DEC_ERR_EN adds a registered dec_err output
// flagging beats whose code has no matching select line.
module reg_select_decoder
    import sel_dec_pkg::*;
#(
    parameter int CODE_W  = DEF_CODE_W,
    parameter int NUM_OUT = DEF_NUM_OUT
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [CODE_W-1:0]  req_code,
    input  logic [CODE_W:0]    req_count,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [NUM_OUT-1:0] out_onehot,
    output logic [CODE_W-1:0]  out_code,
    output logic               out_last,
    output logic               busy
`ifdef SEL_DEC_ERR_EN
    ,
    output logic               dec_err
`endif
);

    localparam logic [CODE_W:0] ONE_BEAT = (CODE_W+1)'(1);

    state_t              state;
    logic [CODE_W:0]     remaining;
    logic [CODE_W:0]     eff_count;
    logic                accept;
    logic                transfer;
    logic [CODE_W-1:0]   next_code;
    logic [NUM_OUT-1:0]  next_onehot;
`ifdef SEL_DEC_ERR_EN
    logic                next_oor;
`endif

    assign req_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = req_valid && req_ready;
    assign transfer  = out_valid && out_ready;
    assign busy      = (state == SWEEP) || out_valid;

    // Normalise the requested beat count: zero means one beat, and a sweep
    // never runs longer than the number of selectable registers.
    always_comb begin
        eff_count = req_count;
        if (req_count == '0)
            eff_count = ONE_BEAT;
        else if (32'(req_count) > NUM_OUT)
            eff_count = (CODE_W+1)'(NUM_OUT);
    end

    // The code loaded next is either the start of a new request or the
    // successor of the beat currently in the output register.
    assign next_code = accept ? req_code
                              : CODE_W'(code_next(32'(out_code), NUM_OUT));

`ifdef SEL_DEC_ERR_EN
    assign next_oor = (32'(next_code) >= NUM_OUT);
`endif

    onehot_decode #(
        .CODE_W  (CODE_W),
        .NUM_OUT (NUM_OUT)
    ) u_onehot_decode (
        .code   (next_code),
        .onehot (next_onehot)
    );

    // Sweep FSM, remaining-beat counter and output beat register: a new
    // request loads its first beat, a transfer in SWEEP loads the next one,
    // and a transfer with nothing pending empties the output register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state      <= IDLE;
            remaining  <= '0;
            out_valid  <= 1'b0;
            out_onehot <= '0;
            out_code   <= '0;
            out_last   <= 1'b0;
`ifdef SEL_DEC_ERR_EN
            dec_err    <= 1'b0;
`endif
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_onehot <= next_onehot;
            out_code   <= next_code;
            out_last   <= (eff_count == ONE_BEAT);
            remaining  <= eff_count - ONE_BEAT;
            state      <= (eff_count > ONE_BEAT) ? SWEEP : IDLE;
`ifdef SEL_DEC_ERR_EN
            dec_err    <= next_oor;
`endif
        end else if (transfer) begin
            if (state == SWEEP) begin
                out_onehot <= next_onehot;
                out_code   <= next_code;
                out_last   <= (remaining == ONE_BEAT);
                remaining  <= remaining - ONE_BEAT;
                state      <= (remaining == ONE_BEAT) ? IDLE : SWEEP;
`ifdef SEL_DEC_ERR_EN
                dec_err    <= next_oor;
`endif
            end else begin
                out_valid  <= 1'b0;
                out_onehot <= '0;
                out_last   <= 1'b0;
`ifdef SEL_DEC_ERR_EN
                dec_err    <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_reg_select_decoder.sv
// Scoreboard bench for reg_select_decoder: one 32-register instance and one
// 24-register instance (for out-of-range codes and wrap at 23). Expected
// beats are queued by the stimulus; a monitor per instance pops and compares
// each beat as it transfers. dec_err is compared when SEL_DEC_ERR_EN is set.
module tb_reg_select_decoder;

    typedef struct {
        logic [31:0] onehot;
        logic [4:0]  code;
        logic        last;
        logic        err;
    } beat_t;

    logic        clk;
    logic        clr_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [4:0]  req_code  [2];
    logic [5:0]  req_count [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [4:0]  out_code  [2];
    logic        out_last  [2];
    logic        busy      [2];
    logic        dec_err   [2];
    logic [31:0] onehot_a;
    logic [23:0] onehot_b;

    beat_t       exp_q0 [$];
    beat_t       exp_q1 [$];
    int          tests_run;
    int          tests_failed;

    reg_select_decoder #(.CODE_W(5), .NUM_OUT(32)) dut_a (
        .clk        (clk),
        .clr_n      (clr_n),
        .req_valid  (req_valid[0]),
        .req_ready  (req_ready[0]),
        .req_code   (req_code[0]),
        .req_count  (req_count[0]),
        .out_valid  (out_valid[0]),
        .out_ready  (out_ready[0]),
        .out_onehot (onehot_a),
        .out_code   (out_code[0]),
        .out_last   (out_last[0]),
        .busy       (busy[0])
`ifdef SEL_DEC_ERR_EN
        ,
        .dec_err    (dec_err[0])
`endif
    );

    reg_select_decoder #(.CODE_W(5), .NUM_OUT(24)) dut_b (
        .clk        (clk),
        .clr_n      (clr_n),
        .req_valid  (req_valid[1]),
        .req_ready  (req_ready[1]),
        .req_code   (req_code[1]),
        .req_count  (req_count[1]),
        .out_valid  (out_valid[1]),
        .out_ready  (out_ready[1]),
        .out_onehot (onehot_b),
        .out_code   (out_code[1]),
        .out_last   (out_last[1]),
        .busy       (busy[1])
`ifdef SEL_DEC_ERR_EN
        ,
        .dec_err    (dec_err[1])
`endif
    );

`ifndef SEL_DEC_ERR_EN
    assign dec_err[0] = 1'b0;
    assign dec_err[1] = 1'b0;
`endif

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the stimulus itself gets stuck.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] stopped");
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic expect_beat(input int sel, input logic [31:0] onehot,
                               input logic [4:0] code, input logic last,
                               input logic err);
        beat_t b;
        b.onehot = onehot;
        b.code   = code;
        b.last   = last;
        b.err    = err;
        if (sel == 0) exp_q0.push_back(b);
        else          exp_q1.push_back(b);
    endtask

    task automatic compare_beat(input int sel, input beat_t b,
                                input logic [31:0] onehot, input logic [4:0] code,
                                input logic last, input logic err);
        check_output($sformatf("dut%0d_onehot", sel), onehot, b.onehot);
        check_output($sformatf("dut%0d_code", sel), 32'(code), 32'(b.code));
        check_output($sformatf("dut%0d_last", sel), 32'(last), 32'(b.last));
`ifdef SEL_DEC_ERR_EN
        check_output($sformatf("dut%0d_dec_err", sel), 32'(err), 32'(b.err));
`else
        if (err !== 1'b0) begin end
`endif
    endtask

    // Scoreboard monitor for the 32-register instance: a beat that will
    // transfer on the coming edge is compared against the oldest expectation.
    always @(negedge clk) begin
        if (clr_n && out_valid[0] && out_ready[0]) begin
            if (exp_q0.size() == 0) begin
                check_output("dut0_unexpected_beat_code", 32'(out_code[0]), 32'hFFFF_FFFF);
            end else begin
                compare_beat(0, exp_q0.pop_front(), onehot_a, out_code[0],
                             out_last[0], dec_err[0]);
            end
        end
    end

    // Scoreboard monitor for the 24-register instance.
    always @(negedge clk) begin
        if (clr_n && out_valid[1] && out_ready[1]) begin
            if (exp_q1.size() == 0) begin
                check_output("dut1_unexpected_beat_code", 32'(out_code[1]), 32'hFFFF_FFFF);
            end else begin
                compare_beat(1, exp_q1.pop_front(), 32'(onehot_b), out_code[1],
                             out_last[1], dec_err[1]);
            end
        end
    end

    // Present a request just after a rising edge and hold it until accepted.
    task automatic apply_stimulus(input int sel, input logic [4:0] code,
                                  input logic [5:0] count, input bit expect_b2b);
        bit got = 1'b0;
        int n   = 0;
        req_valid[sel] = 1'b1;
        req_code[sel]  = code;
        req_count[sel] = count;
        while (!got && n < 100) begin
            @(negedge clk);
            if (req_ready[sel]) begin
                got = 1'b1;
                if (expect_b2b)
                    check_output("b2b_accept_on_last_beat",
                                 32'(out_valid[sel] && out_last[sel]), 32'd1);
            end
            n++;
            @(posedge clk);
            #1;
        end
        req_valid[sel] = 1'b0;
        if (!got) check_output("req_accept_timeout", 32'd0, 32'd1);
    endtask

    // Wait (bounded) until every queued beat for an instance has been seen.
    task automatic drain(input int sel);
        int n = 0;
        while (((sel == 0) ? exp_q0.size() : exp_q1.size()) > 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_output($sformatf("dut%0d_drain_left", sel),
                     (sel == 0) ? exp_q0.size() : exp_q1.size(), 32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        clr_n        = 1'b0;
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0;
            req_code[s]  = '0;
            req_count[s] = '0;
            out_ready[s] = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1 clr_n = 1'b1;
        repeat (2) @(posedge clk);

        // Reset while idle.
        #1 clr_n = 1'b0;
        #1;
        check_output("reset_out_valid", 32'(out_valid[0]), 32'd0);
        check_output("reset_onehot", onehot_a, 32'h0);
        check_output("reset_req_ready", 32'(req_ready[0]), 32'd1);
        check_output("reset_busy", 32'(busy[0]), 32'd0);
        @(posedge clk);
        #1 clr_n = 1'b1;
        @(posedge clk);
        #1;

        // Single beat, then the output register empties.
        expect_beat(0, 32'h0000_0020, 5'd5, 1'b1, 1'b0);
        apply_stimulus(0, 5'd5, 6'd1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_output("single_valid_drops", 32'(out_valid[0]), 32'd0);
        check_output("single_onehot_clears", onehot_a, 32'h0);
        drain(0);
        @(posedge clk);
        #1;

        // Sweep across the 31 -> 0 wrap.
        expect_beat(0, 32'h4000_0000, 5'd30, 1'b0, 1'b0);
        expect_beat(0, 32'h8000_0000, 5'd31, 1'b0, 1'b0);
        expect_beat(0, 32'h0000_0001, 5'd0,  1'b0, 1'b0);
        expect_beat(0, 32'h0000_0002, 5'd1,  1'b1, 1'b0);
        apply_stimulus(0, 5'd30, 6'd4, 1'b0);
        drain(0);
        @(posedge clk);
        #1;

        // Backpressure: stall on the second beat for three cycles.
        expect_beat(0, 32'h0000_0001, 5'd0, 1'b0, 1'b0);
        expect_beat(0, 32'h0000_0002, 5'd1, 1'b0, 1'b0);
        expect_beat(0, 32'h0000_0004, 5'd2, 1'b0, 1'b0);
        expect_beat(0, 32'h0000_0008, 5'd3, 1'b0, 1'b0);
        expect_beat(0, 32'h0000_0010, 5'd4, 1'b0, 1'b0);
        expect_beat(0, 32'h0000_0020, 5'd5, 1'b1, 1'b0);
        apply_stimulus(0, 5'd0, 6'd6, 1'b0);
        @(posedge clk);
        #1 out_ready[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("stall_onehot_held", onehot_a, 32'h0000_0002);
            check_output("stall_code_held", 32'(out_code[0]), 32'd1);
        end
        @(posedge clk);
        #1 out_ready[0] = 1'b1;
        drain(0);
        @(posedge clk);
        #1;

        // Zero beat count behaves as a single beat.
        expect_beat(0, 32'h0000_0080, 5'd7, 1'b1, 1'b0);
        apply_stimulus(0, 5'd7, 6'd0, 1'b0);
        drain(0);
        @(posedge clk);
        #1;

        // Reset in the middle of an 8-beat sweep.
        for (int i = 0; i < 8; i++)
            expect_beat(0, 32'h1 << i, 5'(i), (i == 7), 1'b0);
        apply_stimulus(0, 5'd0, 6'd8, 1'b0);
        repeat (3) @(posedge clk);
        #1 clr_n = 1'b0;
        #1;
        check_output("midreset_beats_left", exp_q0.size(), 32'd5);
        exp_q0.delete();
        check_output("midreset_out_valid", 32'(out_valid[0]), 32'd0);
        check_output("midreset_onehot", onehot_a, 32'h0);
        check_output("midreset_last", 32'(out_last[0]), 32'd0);
        check_output("midreset_busy", 32'(busy[0]), 32'd0);
        @(posedge clk);
        #1 clr_n = 1'b1;
        repeat (3) @(negedge clk);
        check_output("after_reset_no_residual", 32'(out_valid[0]), 32'd0);
        check_output("after_reset_req_ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk);
        #1;

        // 24-register instance: wrap at 23, then an out-of-range code
        // accepted in the same cycle the last sweep beat transfers.
        expect_beat(1, 32'h0040_0000, 5'd22, 1'b0, 1'b0);
        expect_beat(1, 32'h0080_0000, 5'd23, 1'b0, 1'b0);
        expect_beat(1, 32'h0000_0001, 5'd0,  1'b1, 1'b0);
        apply_stimulus(1, 5'd22, 6'd3, 1'b0);
        expect_beat(1, 32'h0000_0000, 5'd26, 1'b1, 1'b1);
        apply_stimulus(1, 5'd26, 6'd1, 1'b1);
        drain(1);
        @(posedge clk);
        #1;

        // Out-of-range code followed by wrap to register 0.
        expect_beat(1, 32'h0000_0000, 5'd30, 1'b0, 1'b1);
        expect_beat(1, 32'h0000_0001, 5'd0,  1'b1, 1'b0);
        apply_stimulus(1, 5'd30, 6'd2, 1'b0);
        drain(1);
        @(posedge clk);
        #1;

        // Oversized count clamps to 24 beats covering every register once.
        for (int i = 0; i < 24; i++)
            expect_beat(1, 32'h1 << i, 5'(i), (i == 23), 1'b0);
        apply_stimulus(1, 5'd0, 6'd31, 1'b0);
        drain(1);
        repeat (2) @(negedge clk);
        check_output("clamp_no_extra_beat", 32'(out_valid[1]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
